// File: rtl/vga_fb_ctrl_if.sv
// Pixel-write port of vga_fb_ctrl: a store-path master pushes {x, y, rgb} writes to the display engine.
interface vga_fb_ctrl_if;
   // Handshake: we is a valid strobe with no ready. A write is taken on the rising edge where we=1.
   // wr_full reflects occupancy at the start of that cycle, and an in-range write seen while full is lost
   // and counted in drop_cnt. The master may keep we high on back-to-back cycles.
   logic        we;
   logic [9:0]  wx;
   logic [9:0]  wy;
   logic [11:0] wrgb;
   logic        wr_full;
   logic [7:0]  drop_cnt;

   modport master (output we, wx, wy, wrgb, input wr_full, drop_cnt);
   modport slave  (input we, wx, wy, wrgb, output wr_full, drop_cnt);
endinterface

// File: rtl/vga_fb_ctrl.sv
// VGA display engine: buffered pixel writes drained into a downscaled framebuffer, scanned at 640x480@60.
// Optional VGA_FB_CLEAR_EN: zero the framebuffer after each reset release before draining writes.
module vga_fb_ctrl #(
   parameter int PIX_DIV    = 4,
   parameter int SCALE_SH   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   vga_fb_ctrl_if.slave wr,
   output logic [3:0]   R,
   output logic [3:0]   G,
   output logic [3:0]   B,
   output logic         hs,
   output logic         vs,
   output logic         dbg_clearing
);
   localparam int FB_W    = 640 >> SCALE_SH;
   localparam int FB_H    = 480 >> SCALE_SH;
   localparam int FB_SIZE = FB_W * FB_H;
   localparam int AW      = $clog2(FB_SIZE);
   localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW      = $clog2(FIFO_DEPTH + 1);
   localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   function automatic logic [AW-1:0] fb_addr(input logic [9:0] x, input logic [9:0] y);
      logic [9:0] xs;
      logic [9:0] ys;
      xs = x >> SCALE_SH;
      ys = y >> SCALE_SH;
      return AW'(int'(ys) * FB_W + int'(xs));
   endfunction

   logic            clearing;
   logic [AW-1:0]   clr_addr;

`ifdef VGA_FB_CLEAR_EN
   typedef enum logic {S_CLEAR, S_RUN} state_t;
   state_t state, state_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_CLEAR;
         clr_addr <= '0;
      end else begin
         state <= state_nx;
         if (state == S_CLEAR) clr_addr <= clr_addr + AW'(1);
      end
   end

   always_comb begin
      state_nx = state;
      clearing = 1'b0;
      case (state)
         S_CLEAR: begin
            clearing = 1'b1;
            if (clr_addr == AW'(FB_SIZE - 1)) state_nx = S_RUN;
         end
         S_RUN:   state_nx = S_RUN;
         default: state_nx = S_RUN;
      endcase
   end
`else
   assign clearing = 1'b0;
   assign clr_addr = '0;
`endif

   assign dbg_clearing = clearing;

   // Write FIFO: entries hold the already-downscaled FB address plus colour.
   logic [AW-1:0] f_addr [FIFO_DEPTH];
   logic [11:0]   f_rgb  [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] occ;
   logic [7:0]    drop_q;
   logic          in_range, full, enq, drop, deq;

   assign in_range    = (wr.wx < 10'd640) && (wr.wy < 10'd480);
   assign full        = (occ == CW'(FIFO_DEPTH));
   assign enq         = wr.we && in_range && !full;
   assign drop        = wr.we && in_range && full;
   assign deq         = (occ != '0) && !clearing;
   assign wr.wr_full  = full;
   assign wr.drop_cnt = drop_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         drop_q <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         if (enq && !deq)      occ <= occ + CW'(1);
         else if (!enq && deq) occ <= occ - CW'(1);
         if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         f_addr[wr_ptr] <= fb_addr(wr.wx, wr.wy);
         f_rgb[wr_ptr]  <= wr.wrgb;
      end
   end

   // Pixel timing
   logic [DW-1:0] div;
   logic [9:0]    hcnt, vcnt;
   logic          tick;

   assign tick = (div == DW'(PIX_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div  <= '0;
         hcnt <= '0;
         vcnt <= '0;
      end else begin
         div <= tick ? '0 : div + DW'(1);
         if (tick) begin
            if (hcnt == 10'd799) begin
               hcnt <= '0;
               vcnt <= (vcnt == 10'd524) ? '0 : vcnt + 10'd1;
            end else begin
               hcnt <= hcnt + 10'd1;
            end
         end
      end
   end

   logic          active, hs_raw, vs_raw;
   logic [AW-1:0] raddr;

   assign active = (hcnt < 10'd640) && (vcnt < 10'd480);
   assign hs_raw = !((hcnt >= 10'd656) && (hcnt <= 10'd751));
   assign vs_raw = !((vcnt >= 10'd490) && (vcnt <= 10'd491));
   assign raddr  = active ? fb_addr(hcnt, vcnt) : '0;

   // Framebuffer: one write port (clear or drain), one scan read port; read returns pre-write data.
   logic [11:0]   fb [FB_SIZE];
   logic          fb_we;
   logic [AW-1:0] fb_waddr;
   logic [11:0]   fb_wdata, pix_rd;

   always_comb begin
      fb_we    = deq;
      fb_waddr = f_addr[rd_ptr];
      fb_wdata = f_rgb[rd_ptr];
      if (clearing) begin
         fb_we    = 1'b1;
         fb_waddr = clr_addr;
         fb_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (fb_we) fb[fb_waddr] <= fb_wdata;
      if (tick)  pix_rd <= fb[raddr];
   end

   // Two-stage scan pipeline; blanking and syncs travel with the pixel data.
   logic act1, hs1, vs1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act1        <= 1'b0;
         hs1         <= 1'b1;
         vs1         <= 1'b1;
         {R, G, B}   <= '0;
         hs          <= 1'b1;
         vs          <= 1'b1;
      end else if (tick) begin
         act1      <= active && !clearing;
         hs1       <= hs_raw;
         vs1       <= vs_raw;
         {R, G, B} <= act1 ? pix_rd : 12'h000;
         hs        <= hs1;
         vs        <= vs1;
      end
   end
endmodule
